// File: rtl/uart_rx_if.sv
// Bus bundle for uart_rx: the serial line and frame configuration going in,
// and the received byte with its status pulses coming out.
interface uart_rx_if;
   logic       RX_IN;
   logic       PAR_EN;
   logic       PAR_TYP;
   logic [7:0] P_DATA;
   logic       DATA_VALID;
   logic       PAR_ERR;
   logic       STP_ERR;
   logic       BUSY;

   modport master (
      output RX_IN, PAR_EN, PAR_TYP,
      input  P_DATA, DATA_VALID, PAR_ERR, STP_ERR, BUSY
   );

   modport slave (
      input  RX_IN, PAR_EN, PAR_TYP,
      output P_DATA, DATA_VALID, PAR_ERR, STP_ERR, BUSY
   );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start, 8 data bits LSB first, optional parity, stop.
// Define UART_RX_MAJORITY_EN for 2-of-3 voting around each bit centre.
module uart_rx #(
   parameter int unsigned OVERSAMPLE = 8
) (
   input  logic      clk,
   input  logic      rst,
   uart_rx_if.slave  bus
);

   localparam int unsigned CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
`ifdef UART_RX_MAJORITY_EN
   localparam int unsigned SAMPLE_AT = OVERSAMPLE / 2 + 1;
`else
   localparam int unsigned SAMPLE_AT = OVERSAMPLE / 2;
`endif
   localparam logic [CNT_W-1:0] DECIDE_CNT = CNT_W'(SAMPLE_AT);
   localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(OVERSAMPLE - 1);
   localparam logic [CNT_W-1:0] ONE_CNT    = CNT_W'(1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_e;

   state_e           state_q, state_d;
   logic             rx_meta_q, rx_meta_d;
   logic             rx_s_q, rx_s_d;
   logic             rx_prev_q, rx_prev_d;
   logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shift_q, shift_d;
   logic             par_en_q, par_en_d;
   logic             par_typ_q, par_typ_d;
   logic             par_bad_q, par_bad_d;
   logic [7:0]       p_data_q, p_data_d;
   logic             data_valid_q, data_valid_d;
   logic             par_err_q, par_err_d;
   logic             stp_err_q, stp_err_d;

   logic start_edge;
   logic decide;
   logic wrap;
   logic bit_val;

   assign start_edge = rx_prev_q & ~rx_s_q;
   assign decide     = (edge_cnt_q == DECIDE_CNT);
   assign wrap       = (edge_cnt_q == LAST_CNT);

`ifdef UART_RX_MAJORITY_EN
   localparam logic [CNT_W-1:0] VOTE0_CNT = CNT_W'(OVERSAMPLE / 2 - 1);
   localparam logic [CNT_W-1:0] VOTE1_CNT = CNT_W'(OVERSAMPLE / 2);

   logic [1:0] vote_q, vote_d;

   always_comb begin
      vote_d = vote_q;
      if (edge_cnt_q == VOTE0_CNT) vote_d[0] = rx_s_q;
      if (edge_cnt_q == VOTE1_CNT) vote_d[1] = rx_s_q;
   end

   // Third vote is the live sample on the decision cycle itself.
   assign bit_val = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s_q) | (vote_q[1] & rx_s_q);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) vote_q <= '0;
      else      vote_q <= vote_d;
   end
`else
   assign bit_val = rx_s_q;
`endif

   always_comb begin
      rx_meta_d    = bus.RX_IN;
      rx_s_d       = rx_meta_q;
      rx_prev_d    = rx_s_q;
      state_d      = state_q;
      edge_cnt_d   = edge_cnt_q;
      bit_idx_d    = bit_idx_q;
      shift_d      = shift_q;
      par_en_d     = par_en_q;
      par_typ_d    = par_typ_q;
      par_bad_d    = par_bad_q;
      p_data_d     = p_data_q;
      data_valid_d = 1'b0;
      par_err_d    = 1'b0;
      stp_err_d    = 1'b0;

      if (state_q != IDLE) edge_cnt_d = wrap ? '0 : edge_cnt_q + ONE_CNT;

      // Decisions happen mid-bit; state advances on the wrap so each state spans its bit.
      case (state_q)
         IDLE: begin
            if (start_edge) begin
               state_d    = START;
               edge_cnt_d = ONE_CNT;
               bit_idx_d  = '0;
               par_en_d   = bus.PAR_EN;
               par_typ_d  = bus.PAR_TYP;
               par_bad_d  = 1'b0;
            end
         end
         START: begin
            if (decide && bit_val) begin
               state_d    = IDLE;
               edge_cnt_d = '0;
            end else if (wrap) begin
               state_d = DATA;
            end
         end
         DATA: begin
            if (decide) shift_d = {bit_val, shift_q[7:1]};
            if (wrap) begin
               if (bit_idx_q == 3'd7) begin
                  bit_idx_d = '0;
                  state_d   = par_en_q ? PARITY : STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
         PARITY: begin
            if (decide) par_bad_d = (bit_val != ((^shift_q) ^ par_typ_q));
            if (wrap) state_d = STOP;
         end
         STOP: begin
            if (decide) begin
               state_d    = IDLE;
               edge_cnt_d = '0;
               if (!bit_val) begin
                  stp_err_d = 1'b1;
               end else if (par_bad_q) begin
                  par_err_d = 1'b1;
               end else begin
                  p_data_d     = shift_q;
                  data_valid_d = 1'b1;
               end
            end
         end
         default: begin
            state_d    = IDLE;
            edge_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_meta_q    <= 1'b1;
         rx_s_q       <= 1'b1;
         rx_prev_q    <= 1'b1;
         state_q      <= IDLE;
         edge_cnt_q   <= '0;
         bit_idx_q    <= '0;
         shift_q      <= '0;
         par_en_q     <= 1'b0;
         par_typ_q    <= 1'b0;
         par_bad_q    <= 1'b0;
         p_data_q     <= '0;
         data_valid_q <= 1'b0;
         par_err_q    <= 1'b0;
         stp_err_q    <= 1'b0;
      end else begin
         rx_meta_q    <= rx_meta_d;
         rx_s_q       <= rx_s_d;
         rx_prev_q    <= rx_prev_d;
         state_q      <= state_d;
         edge_cnt_q   <= edge_cnt_d;
         bit_idx_q    <= bit_idx_d;
         shift_q      <= shift_d;
         par_en_q     <= par_en_d;
         par_typ_q    <= par_typ_d;
         par_bad_q    <= par_bad_d;
         p_data_q     <= p_data_d;
         data_valid_q <= data_valid_d;
         par_err_q    <= par_err_d;
         stp_err_q    <= stp_err_d;
      end
   end

   assign bus.P_DATA     = p_data_q;
   assign bus.DATA_VALID = data_valid_q;
   assign bus.PAR_ERR    = par_err_q;
   assign bus.STP_ERR    = stp_err_q;
   assign bus.BUSY       = (state_q != IDLE);

endmodule

// File: doc/uart_rx.md
# uart_rx

- Oversampling UART receiver: the receive-side counterpart of the team's one-bit-per-frame-slot transmitter.
- Recovers 8-bit frames from the serial line: start bit (0), 8 data bits LSB first, optional parity bit, stop bit (1).
- Presents each byte on a parallel bus with a one-cycle valid pulse, or flags a parity or stop-bit (framing) error.
- Sits between the pad-side RX line and the byte consumer, sharing PAR_EN/PAR_TYP configuration with the transmitter.

## Interface
Parameters:
- OVERSAMPLE, 8: clock cycles per bit period; must be even and ≥ 4.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- RX_IN  in  1  serial line, idle high; asynchronous to clk.
- PAR_EN  in  1  1 = frame carries a parity bit after the data bits.
- PAR_TYP  in  1  parity type: 0 = even (bit = ^data), 1 = odd (bit = ~^data).
- P_DATA  out  8  last received byte; holds its value until the next valid frame.
- DATA_VALID  out  1  one-cycle pulse: P_DATA updated with a good frame.
- PAR_ERR  out  1  one-cycle pulse: parity mismatch; frame discarded.
- STP_ERR  out  1  one-cycle pulse: stop bit sampled 0; frame discarded.
- BUSY  out  1  high while a frame is being received (any state but IDLE).

## Operation
- RX_IN passes through a 2-flop synchronizer (reset value 1); all logic uses the synchronized value rx_s.
- States and transitions:
  - IDLE: wait for rx_s to go 1→0 (edge against the previous rx_s), then go to START.
  - START: if the start sample is 1, treat it as a glitch and go to IDLE with no output. Otherwise go to DATA.
  - DATA: take 8 samples into a shift register, LSB first. Then go to PARITY if PAR_EN = 1, else to STOP.
  - PARITY: compare the sample with the parity computed from the 8 data bits; record any mismatch. Go to STOP.
  - STOP: sample 0 → STP_ERR; else recorded parity mismatch → PAR_ERR; else P_DATA ← shift register and DATA_VALID. Go to IDLE.
- Error priority: STP_ERR wins over PAR_ERR. At most one of DATA_VALID, PAR_ERR, STP_ERR pulses per frame.
- Bit-period counter edge_cnt (width clog2(OVERSAMPLE)):
  - Cleared to 0 on the start-edge cycle; that cycle is count 0 of the start bit.
  - Counts 0..OVERSAMPLE-1, then wraps to 0 and advances the bit index.
  - The bit index counts 0..7 in DATA and resets on each state change.
- PAR_EN and PAR_TYP are sampled on the start-edge cycle and held for the frame. Changing them mid-frame has no effect on that frame.
- Line held low after a stop error (break): no new frame starts until rx_s returns to 1 and falls again.
- Reset values: P_DATA = 0, DATA_VALID = PAR_ERR = STP_ERR = BUSY = 0, state IDLE, all counters 0.
- Asserting rst mid-frame aborts the frame immediately; no pulse is produced after rst is released.

## Timing
- The decision cycle of each bit is at edge_cnt = S, where S = OVERSAMPLE/2 + 1 with majority voting and OVERSAMPLE/2 without it (see Configuration).
- The bit value is resolved on the decision cycle.
- DATA_VALID, PAR_ERR and STP_ERR are registered: they pulse the cycle after the stop-bit decision cycle. P_DATA changes on that same edge.
- From the RX_IN falling edge to the output pulse: 2 synchronizer cycles + (N-1)·OVERSAMPLE + S + 1 cycles, where N = 10 (PAR_EN = 0) or 11 (PAR_EN = 1).
- BUSY rises the cycle after the start edge and falls with the output pulse.
- The receiver re-enters IDLE after the stop decision. A new start edge is accepted from the following cycle, so back-to-back frames are received with no idle gap.

## Configuration
- UART_RX_MAJORITY_EN:
  - Defined: each bit value is the 2-of-3 majority of rx_s at edge_cnt = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. S = OVERSAMPLE/2+1.
  - Undefined: a single sample of rx_s at edge_cnt = OVERSAMPLE/2. S = OVERSAMPLE/2. The vote logic is absent.

## Test plan
- OVERSAMPLE=8, PAR_EN=0: send 0xA5 (10-bit frame, 8 clk/bit) -> one DATA_VALID pulse with P_DATA=0xA5, PAR_ERR=STP_ERR=0, BUSY high for the frame.
- PAR_EN=1, PAR_TYP=0, send 0x3C with parity 0 -> DATA_VALID, P_DATA=0x3C. Repeat with parity 1 -> PAR_ERR pulse, P_DATA keeps 0x3C, no DATA_VALID.
- PAR_EN=1, PAR_TYP=1, send 0x01 with a correct parity bit but stop bit 0 -> STP_ERR only. Line then held low for 40 cycles -> no further pulses until it goes high and falls again.
- 2-cycle low glitch on an idle line -> start rejected, no output pulse, BUSY returns to 0 within OVERSAMPLE cycles.
- With UART_RX_MAJORITY_EN defined, send 0x55 with a 1-cycle inverted spike at each bit centre (edge_cnt=4) -> P_DATA=0x55 and DATA_VALID.
- Two back-to-back frames 0x12, 0x34 with no idle gap -> two DATA_VALID pulses exactly 10·OVERSAMPLE cycles apart. Assert rst at bit 4 of a third frame -> all outputs 0 immediately, no pulse after release.
